// File: rtl/seg_reader_pkg.sv
// Shared definitions for the seven-segment reader: glyph patterns and FSM states.
// Glyph words are ordered {a,b,c,d,e,f,g}, active-high.
// No logic here; imported by seg_reader and seg_glyph_decode.
package seg_reader_pkg;

   localparam logic [6:0] GLYPH_0     = 7'b1111110;
   localparam logic [6:0] GLYPH_1     = 7'b0110000;
   localparam logic [6:0] GLYPH_2     = 7'b1101101;
   localparam logic [6:0] GLYPH_3     = 7'b1111001;
   localparam logic [6:0] GLYPH_4     = 7'b0110011;
   localparam logic [6:0] GLYPH_5     = 7'b1011011;
   localparam logic [6:0] GLYPH_6     = 7'b1011111;
   localparam logic [6:0] GLYPH_7     = 7'b1110000;
   localparam logic [6:0] GLYPH_8     = 7'b1111111;
   localparam logic [6:0] GLYPH_9     = 7'b1111011;
   localparam logic [6:0] GLYPH_A     = 7'b1110111;
   localparam logic [6:0] GLYPH_B     = 7'b0011111;
   localparam logic [6:0] GLYPH_C     = 7'b1001110;
   localparam logic [6:0] GLYPH_D     = 7'b0111101;
   localparam logic [6:0] GLYPH_E     = 7'b1001111;
   localparam logic [6:0] GLYPH_F     = 7'b1000111;
   localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      HOLD     = 2'd2,
      WAIT_CHG = 2'd3
   } state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Purpose: exact-match inverse of the segment glyph table (pattern -> value, blank, err).
// Latency: purely combinational.
// Backpressure: none. Hex letters decode only when SEG_READER_HEX_EN is defined.
module seg_glyph_decode
   import seg_reader_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] number,
   output logic       blank,
   output logic       err
);

   // Table lookup; anything not listed is an illegal glyph and reads as 0.
   always_comb begin
      number = 4'd0;
      blank  = 1'b0;
      err    = 1'b0;
      case (seg)
         GLYPH_0:     number = 4'd0;
         GLYPH_1:     number = 4'd1;
         GLYPH_2:     number = 4'd2;
         GLYPH_3:     number = 4'd3;
         GLYPH_4:     number = 4'd4;
         GLYPH_5:     number = 4'd5;
         GLYPH_6:     number = 4'd6;
         GLYPH_7:     number = 4'd7;
         GLYPH_8:     number = 4'd8;
         GLYPH_9:     number = 4'd9;
`ifdef SEG_READER_HEX_EN
         GLYPH_A:     number = 4'd10;
         GLYPH_B:     number = 4'd11;
         GLYPH_C:     number = 4'd12;
         GLYPH_D:     number = 4'd13;
         GLYPH_E:     number = 4'd14;
         GLYPH_F:     number = 4'd15;
`endif
         GLYPH_BLANK: blank  = 1'b1;
         default:     err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_reader.sv
// Purpose: watch a multiplexed 7-segment display, debounce each digit and report its value.
// Latency: result valid after edge STABLE_CYCLES+1 of a constant pattern (edge 4 at default).
// Backpressure: result held frozen while valid && !ready; hex glyphs enabled by SEG_READER_HEX_EN.
module seg_reader
   import seg_reader_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 3
)
(
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    a,
   input  logic                                    b,
   input  logic                                    c,
   input  logic                                    d,
   input  logic                                    e,
   input  logic                                    f,
   input  logic                                    g,
   input  logic [DIGITS-1:0]                       digit_sel,
   input  logic                                    ready,
   output logic                                    valid,
   output logic [3:0]                              number,
   output logic [(DIGITS > 1 ? $clog2(DIGITS) : 1)-1:0] digit_idx,
   output logic                                    blank,
   output logic                                    err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = (STABLE_CYCLES > 0) ? $clog2(STABLE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   function automatic logic is_onehot(input logic [DIGITS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[i]) n++;
      end
      return (n == 1);
   endfunction

   function automatic logic [IDX_W-1:0] onehot_idx(input logic [DIGITS-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   state_t             state_q, state_d;
   logic [6:0]         smp_seg_q, smp_seg_d;
   logic [DIGITS-1:0]  smp_sel_q, smp_sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_raw;
   logic [6:0]         cap_seg_q, cap_seg_d;
   logic [DIGITS-1:0]  cap_sel_q, cap_sel_d;
   logic [3:0]         number_q, number_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               blank_q, blank_d;
   logic               err_q, err_d;

   logic [3:0]         dec_number;
   logic               dec_blank;
   logic               dec_err;
   logic               smp_onehot;

   seg_glyph_decode u_decode (
      .seg    (smp_seg_q),
      .number (dec_number),
      .blank  (dec_blank),
      .err    (dec_err)
   );

   // Sample the pins and advance the saturating stability count (incoming vs. last sample).
   always_comb begin
      smp_seg_d = {a, b, c, d, e, f, g};
      smp_sel_d = digit_sel;
      cnt_raw   = cnt_q;
      if ((smp_seg_d != smp_seg_q) || (smp_sel_d != smp_sel_q) || !is_onehot(smp_sel_d)) begin
         cnt_raw = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_raw = cnt_q + 1'b1;
      end
   end

   assign smp_onehot = is_onehot(smp_sel_q);

   // Next-state logic: settle, capture on entry to HOLD, then wait for a change before re-arming.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_raw;
      cap_seg_d = cap_seg_q;
      cap_sel_d = cap_sel_q;
      number_d  = number_q;
      idx_d     = idx_q;
      blank_d   = blank_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (smp_onehot) state_d = SETTLE;
         end
         SETTLE: begin
            if (!smp_onehot) begin
               state_d = IDLE;
            end else if (cnt_raw == CNT_MAX) begin
               state_d   = HOLD;
               cap_seg_d = smp_seg_q;
               cap_sel_d = smp_sel_q;
               number_d  = dec_number;
               idx_d     = onehot_idx(smp_sel_q);
               blank_d   = dec_blank;
               err_d     = dec_err;
            end
         end
         HOLD: begin
            if (ready) state_d = WAIT_CHG;
         end
         WAIT_CHG: begin
            // The same digit still on display must not be reported twice.
            if ((smp_seg_q != cap_seg_q) || (smp_sel_q != cap_sel_q)) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, sample and result registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         smp_seg_q <= '0;
         smp_sel_q <= '0;
         cnt_q     <= '0;
         cap_seg_q <= '0;
         cap_sel_q <= '0;
         number_q  <= '0;
         idx_q     <= '0;
         blank_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         smp_seg_q <= smp_seg_d;
         smp_sel_q <= smp_sel_d;
         cnt_q     <= cnt_d;
         cap_seg_q <= cap_seg_d;
         cap_sel_q <= cap_sel_d;
         number_q  <= number_d;
         idx_q     <= idx_d;
         blank_q   <= blank_d;
         err_q     <= err_d;
      end
   end

   assign valid     = (state_q == HOLD);
   assign number    = number_q;
   assign digit_idx = idx_q;
   assign blank     = blank_q;
   assign err       = err_q;

endmodule

// File: tb/tb_seg_reader.sv
// Directed self-checking bench for seg_reader at default parameters.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
// Hex expectations follow SEG_READER_HEX_EN.
module tb_seg_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       a, b, c, d, e, f, g;
   logic [3:0] digit_sel;
   logic       ready;
   logic       valid;
   logic [3:0] number;
   logic [1:0] digit_idx;
   logic       blank;
   logic       err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg_reader dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .e         (e),
      .f         (f),
      .g         (g),
      .digit_sel (digit_sel),
      .ready     (ready),
      .valid     (valid),
      .number    (number),
      .digit_idx (digit_idx),
      .blank     (blank),
      .err       (err)
   );

   task automatic set_in(input logic [6:0] seg, input logic [3:0] sel);
      {a, b, c, d, e, f, g} = seg;
      digit_sel = sel;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ready = 1'b0;
      set_in(7'b0000000, 4'b0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({valid, number, digit_idx, blank, err} !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 000000000", {valid, number, digit_idx, blank, err});
      end
      checks++;
      if (dut.state_q !== seg_reader_pkg::IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d expected IDLE", dut.state_q);
      end
   endtask

   task automatic test_basic();
      do_reset();
      set_in(7'b1111001, 4'b0001);
      tick(3);
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early: valid=%b after edge 3 expected 0", valid);
      end
      tick(1);
      checks++;
      if ({valid, number, digit_idx, blank, err} !== {1'b1, 4'd3, 2'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_result: got v=%b n=%0d i=%0d bl=%b er=%b expected v=1 n=3 i=0 bl=0 er=0",
                  valid, number, digit_idx, blank, err);
      end
      ready = 1'b1;
      tick(1);
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_handshake: valid=%b expected 0", valid);
      end
      ready = 1'b0;
   endtask

   task automatic test_glitch();
      int nres;
      int first;
      logic [3:0] n_seen;
      logic [1:0] i_seen;
      do_reset();
      ready = 1'b1;
      nres = 0;
      first = -1;
      n_seen = 4'hF;
      i_seen = 2'd0;
      set_in(7'b0110000, 4'b0100);
      for (int k = 1; k <= 14; k++) begin
         if (k == 3) set_in(7'b1101101, 4'b0100);
         tick(1);
         if (valid === 1'b1) begin
            nres++;
            if (first < 0) begin
               first = k;
               n_seen = number;
               i_seen = digit_idx;
            end
         end
      end
      ready = 1'b0;
      checks++;
      if (nres != 1) begin
         errors++;
         $display("FAIL glitch_count: got %0d results expected 1", nres);
      end
      checks++;
      if (first != 6) begin
         errors++;
         $display("FAIL glitch_edge: valid first after edge %0d expected 6", first);
      end
      checks++;
      if ({n_seen, i_seen} !== {4'd2, 2'd2}) begin
         errors++;
         $display("FAIL glitch_value: got n=%0d i=%0d expected n=2 i=2", n_seen, i_seen);
      end
   endtask

   task automatic test_decode(input logic [6:0] seg, input logic [3:0] sel,
                              input logic [3:0] exp_n, input logic [1:0] exp_i,
                              input logic exp_bl, input logic exp_er);
      do_reset();
      set_in(seg, sel);
      tick(4);
      checks++;
      if ({valid, number, digit_idx, blank, err} !== {1'b1, exp_n, exp_i, exp_bl, exp_er}) begin
         errors++;
         $display("FAIL decode_%b: got v=%b n=%0d i=%0d bl=%b er=%b expected v=1 n=%0d i=%0d bl=%b er=%b",
                  seg, valid, number, digit_idx, blank, err, exp_n, exp_i, exp_bl, exp_er);
      end
   endtask

   task automatic test_hold_and_back_to_back();
      int nres;
      int first;
      do_reset();
      set_in(7'b1111111, 4'b0010);
      tick(4);
      for (int k = 0; k < 5; k++) begin
         set_in(7'b0110000 ^ 7'(k), 4'(1 << (k % 4)));
         tick(1);
         checks++;
         if ({valid, number, digit_idx, blank, err} !== {1'b1, 4'd8, 2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hold_stable_%0d: got v=%b n=%0d i=%0d bl=%b er=%b expected v=1 n=8 i=1 bl=0 er=0",
                     k, valid, number, digit_idx, blank, err);
         end
      end
      set_in(7'b1111111, 4'b0010);
      tick(1);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: valid=%b expected 0", valid);
      end
      nres = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (valid === 1'b1) nres++;
      end
      checks++;
      if (nres != 0) begin
         errors++;
         $display("FAIL no_reemit: got %0d cycles valid expected 0", nres);
      end
      // A new digit after the transfer re-arms through SETTLE.
      set_in(7'b1011111, 4'b0100);
      first = -1;
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         if (valid === 1'b1 && first < 0) first = k;
      end
      checks++;
      if (first != 5) begin
         errors++;
         $display("FAIL b2b_edge: valid first after edge %0d expected 5", first);
      end
      checks++;
      if ({number, digit_idx} !== {4'd6, 2'd2}) begin
         errors++;
         $display("FAIL b2b_value: got n=%0d i=%0d expected n=6 i=2", number, digit_idx);
      end
   endtask

   task automatic test_multihot();
      int nres;
      do_reset();
      set_in(7'b1111001, 4'b0110);
      nres = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (valid === 1'b1) nres++;
      end
      checks++;
      if (nres != 0) begin
         errors++;
         $display("FAIL multihot_valid: got %0d cycles valid expected 0", nres);
      end
      set_in(7'b1111001, 4'b0001);
      tick(2);
      checks++;
      if (dut.state_q !== seg_reader_pkg::SETTLE) begin
         errors++;
         $display("FAIL settle_state: got %0d expected SETTLE", dut.state_q);
      end
      set_in(7'b1111001, 4'b0000);
      tick(2);
      checks++;
      if (dut.state_q !== seg_reader_pkg::IDLE || valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_sel_idle: got state=%0d valid=%b expected IDLE valid=0", dut.state_q, valid);
      end
   endtask

   task automatic test_reset_in_hold();
      do_reset();
      set_in(7'b0110011, 4'b0100);
      tick(4);
      checks++;
      if ({valid, number, digit_idx} !== {1'b1, 4'd4, 2'd2}) begin
         errors++;
         $display("FAIL pre_reset_hold: got v=%b n=%0d i=%0d expected v=1 n=4 i=2", valid, number, digit_idx);
      end
      ready = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({valid, number, digit_idx, blank, err} !== 9'b0) begin
         errors++;
         $display("FAIL async_reset: got %b expected 000000000", {valid, number, digit_idx, blank, err});
      end
      ready = 1'b0;
      #1;
      reset = 1'b0;
      tick(3);
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_early: valid=%b after edge 3 expected 0", valid);
      end
      tick(1);
      checks++;
      if ({valid, number, digit_idx, blank, err} !== {1'b1, 4'd4, 2'd2, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_result: got v=%b n=%0d i=%0d bl=%b er=%b expected v=1 n=4 i=2 bl=0 er=0",
                  valid, number, digit_idx, blank, err);
      end
   endtask

   initial begin
      reset = 1'b1;
      ready = 1'b0;
      set_in(7'b0000000, 4'b0000);
      test_reset();
      test_basic();
      test_glitch();
`ifdef SEG_READER_HEX_EN
      test_decode(7'b1110111, 4'b1000, 4'd10, 2'd3, 1'b0, 1'b0);
      test_decode(7'b1000111, 4'b0001, 4'd15, 2'd0, 1'b0, 1'b0);
`else
      test_decode(7'b1110111, 4'b1000, 4'd0, 2'd3, 1'b0, 1'b1);
      test_decode(7'b1000111, 4'b0001, 4'd0, 2'd0, 1'b0, 1'b1);
`endif
      test_decode(7'b0000000, 4'b0010, 4'd0, 2'd1, 1'b1, 1'b0);
      test_decode(7'b1010101, 4'b0100, 4'd0, 2'd2, 1'b0, 1'b1);
      test_decode(7'b1111011, 4'b1000, 4'd9, 2'd3, 1'b0, 1'b0);
      test_decode(7'b1110000, 4'b0010, 4'd7, 2'd1, 1'b0, 1'b0);
      test_hold_and_back_to_back();
      test_multihot();
      test_reset_in_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digit positions watched.
REQ-002 SHALL have parameter STABLE_CYCLES, default 3: consecutive identical samples required before decoding.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports a, b, c, d, e, f, g  input  1 each  segment lines, active-high, in the order of the team's 7-bit segment word {a,b,c,d,e,f,g}.
REQ-006 SHALL have port digit_sel  input  DIGITS  one-hot select identifying the digit currently driven.
REQ-007 SHALL have port ready  input  1  consumer accepts the result.
REQ-008 SHALL have port valid  output  1  result held and awaiting ready.
REQ-009 SHALL have port number  output  4  decoded value.
REQ-010 SHALL have port digit_idx  output  clog2(DIGITS)  binary index of the one-hot digit_sel bit.
REQ-011 SHALL have port blank  output  1  captured pattern was all-off.
REQ-012 SHALL have port err  output  1  captured pattern was not a legal glyph.

Function
REQ-013 SHALL register {a..g, digit_sel} into a sample register every cycle; all decisions use the registered sample only.
REQ-014 SHALL keep a saturating stability counter: clear when the new sample differs from the previous sample or digit_sel is not exactly one-hot; otherwise increment.
REQ-015 SHALL implement states IDLE, SETTLE, HOLD, WAIT_CHG.
REQ-016 IDLE -> SETTLE when the sample is one-hot; SETTLE -> IDLE when digit_sel becomes non-one-hot (zero or multi-hot).
REQ-017 SETTLE -> HOLD when the counter reaches STABLE_CYCLES; a pattern presented on cycle 1 and held constant SHALL raise valid after rising edge STABLE_CYCLES+1 (edge 4 at default).
REQ-018 On entry to HOLD SHALL capture number, digit_idx, blank and err, and hold them constant while valid=1, regardless of input changes.
REQ-019 Decoding SHALL be exact-match inverse of the team's glyph table: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
REQ-020 Pattern 0000000 SHALL give blank=1, err=0, number=0; any other unlisted pattern SHALL give err=1, blank=0, number=0.
REQ-021 HOLD: valid=1 until the edge where ready=1, then valid=0 on the next cycle and state -> WAIT_CHG; ready already high on entry SHALL complete the transfer in one cycle.
REQ-022 WAIT_CHG SHALL suppress re-emission of the captured digit and move to SETTLE with the counter cleared only when the sample differs from the captured {segments, digit_sel}.
REQ-023 A glitch shorter than STABLE_CYCLES SHALL restart the count and emit nothing.

Reset
REQ-024 reset SHALL asynchronously force state IDLE, counter 0, sample register 0, valid=0, number=0, digit_idx=0, blank=0, err=0.
REQ-025 Reset asserted during HOLD SHALL drop valid immediately, with no handshake completion.

Configuration
REQ-026 With SEG_READER_HEX_EN defined, the block SHALL also decode 1110111->A, 0011111->b, 1001110->C, 0111101->d, 1001111->E, 1000111->F as values 10-15, with err=0.
REQ-027 Without SEG_READER_HEX_EN, those six patterns SHALL give err=1 and number=0.

Structure
REQ-028 A shared package seg_reader_pkg SHALL hold the glyph pattern constants (0-9, A-F, blank) and the state enumeration.
REQ-029 The pattern-to-value inverse table SHALL be a combinational sub-module seg_glyph_decode, instantiated once.

Verification
REQ-030 Present 1111001 with digit_sel=0001, held constant -> valid=1 after edge 4, number=3, digit_idx=0, blank=0, err=0.
REQ-031 Present 0110000 with sel=0100 for 2 cycles, then 1101101 held -> exactly one result, number=2, digit_idx=2; no result for 1.
REQ-032 Present 1110111 with sel=1000 -> number=10, err=0 with SEG_READER_HEX_EN defined; number=0, err=1 without it.
REQ-033 Hold ready=0 for 5 cycles during valid while changing the inputs -> outputs unchanged; after ready=1, same digit held again -> no re-emission.
REQ-034 digit_sel=0110 with a legal pattern -> valid never rises; digit_sel=0 -> state returns to IDLE.
REQ-035 Assert reset mid-HOLD -> valid=0 immediately and all outputs 0; after release, the same stable input -> a fresh result after 4 edges.
